clk_rst_sequencer: RTL
======================

Name: clk_rst_sequencer

Overview:
- Sits directly downstream of the on-chip 25/50 MHz RC oscillator and its fabric CCC/PLL.
- Runs on the oscillator-derived fabric clock and waits for a stable PLL lock.
- Then releases block resets in order: camera (OV7725), SCCB configuration, LCD pipeline. It asserts sys_ready once all are running.
- Watches lock during operation. It recovers by pulsing the CCC reset when lock never arrives or is lost.

Parameters:
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized lock-high cycles required before leaving WAIT_LOCK.
- STAGE_GAP_CYCLES, 256, cycles between camera reset release and config reset release.
- CFG_TIMEOUT_CYCLES, 1048576, maximum cycles to wait for cfg_done after releasing cfg_rst_n.
- LOCK_TIMEOUT_CYCLES, 65536, cycles in WAIT_LOCK without qualified lock before a CCC reset pulse.
- CCC_RST_CYCLES, 16, width of the ccc_rst_n low pulse.
- MAX_RETRIES, 3, lock-timeout retries before fault latches.

Ports:
- clk  input  1  fabric clock from oscillator/CCC.
- rst_n  input  1  synchronous active-low reset.
- pll_lock  input  1  CCC lock, asynchronous to clk.
- cfg_done  input  1  level from the SCCB config block, synchronous to clk.
- ccc_rst_n  output  1  active-low reset to the CCC.
- cam_rst_n  output  1  active-low reset to the camera interface.
- cfg_rst_n  output  1  active-low reset to the SCCB config block.
- lcd_rst_n  output  1  active-low reset to the LCD pipeline.
- sys_ready  output  1  high in RUN only.
- fault  output  1  sticky; set on retry exhaustion or config timeout.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - When rst_n=0 at a clk edge: state=WAIT_LOCK; all counters=0; retry count=0; fault=0; synchronizer flops=0.
  - Outputs during reset: ccc_rst_n=1, cam_rst_n=0, cfg_rst_n=0, lcd_rst_n=0, sys_ready=0.
  - Reset mid-operation returns to these values on the same edge.
- pll_lock passes through a 2-flop synchronizer (lock_s), giving 2 cycles latency. cfg_done is used directly.
- All outputs are registered and decoded from the next state, so they are valid in the same cycle the state is entered.
- State encodings: WAIT_LOCK=0, CCC_RST=1, REL_CAM=2, REL_CFG=3, REL_LCD=4, RUN=5, FAULT=6.
- WAIT_LOCK:
  - All block resets are low.
  - lock_cnt increments while lock_s=1 and clears when lock_s=0.
  - When lock_cnt==LOCK_STABLE_CYCLES-1 and lock_s=1: go to REL_CAM.
  - to_cnt counts every cycle in WAIT_LOCK. On to_cnt==LOCK_TIMEOUT_CYCLES-1 without qualification: if retries<MAX_RETRIES, increment retries and go to CCC_RST; else go to FAULT.
  - If qualification and timeout hit in the same cycle, qualification wins.
- CCC_RST:
  - ccc_rst_n=0 for exactly CCC_RST_CYCLES cycles, then back to WAIT_LOCK with lock_cnt and to_cnt cleared.
  - lock_s is ignored in this state.
- REL_CAM:
  - cam_rst_n=1.
  - After STAGE_GAP_CYCLES cycles in the state, go to REL_CFG.
- REL_CFG:
  - cam_rst_n=1 and cfg_rst_n=1.
  - If cfg_done=1, go to REL_LCD on the next edge.
  - After CFG_TIMEOUT_CYCLES cycles without cfg_done, go to FAULT.
- REL_LCD:
  - All three block resets are high for one cycle, then go to RUN.
- RUN:
  - sys_ready=1; retries cleared to 0.
- Lock loss:
  - In REL_CAM, REL_CFG, REL_LCD or RUN, lock_s=0 has priority over every other transition.
  - On that edge: go to WAIT_LOCK, drive all block resets low and sys_ready=0, clear counters. Retries are not incremented.
- FAULT:
  - fault=1; all block resets low; ccc_rst_n=1; sys_ready=0.
  - Exit only via rst_n.
- Counter widths are $clog2 of the respective parameter (minimum 1). Counters do not wrap: each is cleared on state entry.

Test Plan:
1. Small params: LOCK_STABLE=8, STAGE_GAP=4, CFG_TIMEOUT=32, LOCK_TIMEOUT=64, CCC_RST=4, MAX_RETRIES=2. pll_lock=1 before reset release, cfg_done=1 held -> cam_rst_n rises 10 edges after the first post-reset edge (2 sync + 8 qualify); cfg_rst_n rises 4 cycles later; lcd_rst_n 1 cycle after that; sys_ready 1 cycle later; state_o=5.
2. pll_lock toggles low once every 6 cycles -> never leaves WAIT_LOCK; after 64 cycles ccc_rst_n is low exactly 4 cycles; after the third timeout fault=1 and state_o=6.
3. Stable lock, cfg_done held 0 -> cfg_rst_n high for 32 cycles, then fault=1 and cam_rst_n=cfg_rst_n=0.
4. In RUN, drop pll_lock for 1 cycle -> 2 cycles later sys_ready=0, all block resets low, state_o=0; re-qualification takes 8 cycles; ccc_rst_n stays 1.
5. rst_n=0 for 1 cycle while in REL_CFG -> next edge shows all reset-state outputs, and fault is cleared.
6. Lock qualifies on the exact cycle to_cnt reaches 63 -> goes to REL_CAM with no ccc_rst_n pulse.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
`timescale 1ns/1ps
// Power-up sequencer: qualifies PLL lock, then releases camera, SCCB config and LCD resets in order.
// Latency: 2-cycle lock synchronizer, outputs registered from next state; no backpressure, lock loss or timeouts force recovery.
module clk_rst_sequencer #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 256,
    parameter int CFG_TIMEOUT_CYCLES  = 1048576,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CCC_RST_CYCLES      = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_done,
    output logic       ccc_rst_n,
    output logic       cam_rst_n,
    output logic       cfg_rst_n,
    output logic       lcd_rst_n,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_CCC_RST   = 3'd1;
    localparam logic [2:0] S_REL_CAM   = 3'd2;
    localparam logic [2:0] S_REL_CFG   = 3'd3;
    localparam logic [2:0] S_REL_LCD   = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    localparam int LW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int GW = (STAGE_GAP_CYCLES    > 1) ? $clog2(STAGE_GAP_CYCLES)    : 1;
    localparam int FW = (CFG_TIMEOUT_CYCLES  > 1) ? $clog2(CFG_TIMEOUT_CYCLES)  : 1;
    localparam int CW = (CCC_RST_CYCLES      > 1) ? $clog2(CCC_RST_CYCLES)      : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP_CYCLES - 1);
    localparam logic [FW-1:0] CFG_LAST   = FW'(CFG_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CCC_LAST   = CW'(CCC_RST_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    logic          sync1;
    logic          lock_s;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] cfg_cnt;
    logic [CW-1:0] ccc_cnt;
    logic [RW-1:0] retries;

    assign state_o = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT_LOCK: begin
                // Qualification is tested first so it wins a tie with the timeout.
                if (lock_s && (lock_cnt == LOCK_LAST))
                    state_nxt = S_REL_CAM;
                else if (to_cnt == TO_LAST)
                    state_nxt = (retries < RETRY_MAX) ? S_CCC_RST : S_FAULT;
            end
            S_CCC_RST: begin
                if (ccc_cnt == CCC_LAST)
                    state_nxt = S_WAIT_LOCK;
            end
            S_REL_CAM: begin
                if (!lock_s)
                    state_nxt = S_WAIT_LOCK;
                else if (gap_cnt == GAP_LAST)
                    state_nxt = S_REL_CFG;
            end
            S_REL_CFG: begin
                if (!lock_s)
                    state_nxt = S_WAIT_LOCK;
                else if (cfg_done)
                    state_nxt = S_REL_LCD;
                else if (cfg_cnt == CFG_LAST)
                    state_nxt = S_FAULT;
            end
            S_REL_LCD: begin
                state_nxt = lock_s ? S_RUN : S_WAIT_LOCK;
            end
            S_RUN: begin
                if (!lock_s)
                    state_nxt = S_WAIT_LOCK;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_WAIT_LOCK;
            lock_cnt  <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            cfg_cnt   <= '0;
            ccc_cnt   <= '0;
            retries   <= '0;
            ccc_rst_n <= 1'b1;
            cam_rst_n <= 1'b0;
            cfg_rst_n <= 1'b0;
            lcd_rst_n <= 1'b0;
            sys_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
            state  <= state_nxt;

            // Every counter restarts on state entry, so none can wrap.
            if (state_nxt != state) begin
                lock_cnt <= '0;
                to_cnt   <= '0;
                gap_cnt  <= '0;
                cfg_cnt  <= '0;
                ccc_cnt  <= '0;
            end else begin
                case (state)
                    S_WAIT_LOCK: begin
                        lock_cnt <= lock_s ? lock_cnt + 1'b1 : '0;
                        to_cnt   <= to_cnt + 1'b1;
                    end
                    S_CCC_RST: ccc_cnt <= ccc_cnt + 1'b1;
                    S_REL_CAM: gap_cnt <= gap_cnt + 1'b1;
                    S_REL_CFG: cfg_cnt <= cfg_cnt + 1'b1;
                    default: ;
                endcase
            end

            if ((state == S_WAIT_LOCK) && (state_nxt == S_CCC_RST))
                retries <= retries + 1'b1;
            else if (state_nxt == S_RUN)
                retries <= '0;

            // FAULT is absorbing, so decoding fault from it keeps the flag sticky.
            ccc_rst_n <= (state_nxt != S_CCC_RST);
            cam_rst_n <= (state_nxt inside {S_REL_CAM, S_REL_CFG, S_REL_LCD, S_RUN});
            cfg_rst_n <= (state_nxt inside {S_REL_CFG, S_REL_LCD, S_RUN});
            lcd_rst_n <= (state_nxt inside {S_REL_LCD, S_RUN});
            sys_ready <= (state_nxt == S_RUN);
            fault     <= (state_nxt == S_FAULT);
        end
    end

endmodule
